// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch-queue cache fetch controller.
package ifq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;

  localparam int unsigned LINE_OFFSET_BITS = 4;

endpackage

// File: rtl/ifq_fetch_ctrl_if.sv
// I-cache request/response port between the fetch controller (master) and the cache (slave).
interface ifq_fetch_ctrl_if #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128
);
  logic                        cache_rd_req;
  logic [DATA_WIDTH-1:0]       cache_addr;
  logic                        cache_abort;
  logic                        cache_req_ready;
  logic                        cache_rsp_valid;
  logic [CACHE_LINE_WIDTH-1:0] cache_rsp_data;

  modport master (
    output cache_rd_req, cache_addr, cache_abort,
    input  cache_req_ready, cache_rsp_valid, cache_rsp_data
  );

  modport slave (
    input  cache_rd_req, cache_addr, cache_abort,
    output cache_req_ready, cache_rsp_valid, cache_rsp_data
  );
endinterface

// File: rtl/ifq_fetch_ctrl_up_down_sat_counter.sv
// Up/down counter saturating at 0 and MAX; load has priority, simultaneous inc/dec holds.
module up_down_sat_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MAX     = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= WIDTH'(RST_VAL);
    end else if (load) begin
      r_count <= load_val;
    end else if (inc && !dec && r_count < WIDTH'(MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (dec && !inc && r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Issues line-aligned I-cache reads for the IFQ under credit and outstanding limits,
// and discards stale responses after a branch redirect.
module ifq_fetch_ctrl
  import ifq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned MAX_OUTSTANDING  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  input  logic [DATA_WIDTH-1:0]       pc_in,
  input  logic                        jmp_branch_valid,
  input  logic                        ifq_line_free,
  output logic                        pc_advance,
  ifq_fetch_ctrl_if.master            cache,
  output logic [CACHE_LINE_WIDTH-1:0] d_out,
  output logic                        d_out_valid,
  output logic                        busy,
  output logic                        rsp_err
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] LINE_MASK =
    {{(DATA_WIDTH - LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  fetch_state_t                r_state, w_state_nxt;
  logic [OW-1:0]               r_kill_cnt, w_kill_nxt, w_kill_init;
  logic [OW-1:0]               w_outstanding, w_out_nxt;
  logic [CW-1:0]               w_credits;
  logic [CACHE_LINE_WIDTH-1:0] r_d_out;
  logic                        r_d_out_valid, r_abort, r_busy, r_rsp_err;
  logic                        w_req, w_xfer, w_rsp_ok, w_rsp_err;
  logic                        w_flush_start, w_flush_now, w_deliver;

  assign w_req = (r_state == RUN) && (w_credits != '0) &&
                 (w_outstanding < OW'(MAX_OUTSTANDING)) && !jmp_branch_valid;
  assign w_xfer        = w_req && cache.cache_req_ready;
  assign w_rsp_ok      = cache.cache_rsp_valid && (w_outstanding != '0);
  assign w_rsp_err     = cache.cache_rsp_valid && (w_outstanding == '0);
  assign w_flush_start = (r_state == RUN) && jmp_branch_valid;
  assign w_flush_now   = (r_state == FLUSH) || w_flush_start;
  assign w_deliver     = w_rsp_ok && (r_kill_cnt == '0) && !w_flush_now;
  assign w_kill_init   = w_outstanding - OW'(w_rsp_ok);
  assign w_out_nxt     = w_outstanding + OW'(w_xfer) - OW'(w_rsp_ok);

  up_down_sat_counter #(.WIDTH(CW), .MAX(FIFO_DEPTH), .RST_VAL(FIFO_DEPTH)) u_credits (
    .clk      (clk),
    .rst      (rst),
    .inc      (ifq_line_free),
    .dec      (w_xfer),
    .load     (jmp_branch_valid),
    .load_val (CW'(FIFO_DEPTH)),
    .count    (w_credits)
  );

  up_down_sat_counter #(.WIDTH(OW), .MAX(MAX_OUTSTANDING), .RST_VAL(0)) u_outstanding (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_xfer),
    .dec      (w_rsp_ok),
    .load     (1'b0),
    .load_val ('0),
    .count    (w_outstanding)
  );

  // A redirect drops the same-cycle response itself, so kill_cnt only counts later ones.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill_cnt;
    if (w_flush_start) begin
      w_kill_nxt = w_kill_init;
    end else if (w_rsp_ok && r_kill_cnt != '0) begin
      w_kill_nxt = r_kill_cnt - OW'(1);
    end
    case (r_state)
      IDLE:  if (fetch_en) w_state_nxt = RUN;
      RUN: begin
        if (w_flush_start) begin
          if (w_kill_init != '0) w_state_nxt = FLUSH;
        end else if (!fetch_en && !(w_req && !cache.cache_req_ready)) begin
          w_state_nxt = IDLE;
        end
      end
      FLUSH: if (w_kill_nxt == '0) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_kill_cnt    <= '0;
      r_d_out       <= '0;
      r_d_out_valid <= 1'b0;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_kill_cnt    <= w_kill_nxt;
      r_d_out_valid <= w_deliver;
      if (w_deliver) r_d_out <= cache.cache_rsp_data;
      r_abort       <= (w_state_nxt == FLUSH);
      r_busy        <= (w_out_nxt != '0) || (w_state_nxt != IDLE);
      if (w_rsp_err) r_rsp_err <= 1'b1;
    end
  end

  assign pc_advance         = w_xfer;
  assign cache.cache_rd_req = w_req;
  assign cache.cache_addr   = (r_state == IDLE) ? '0 : (pc_in & LINE_MASK);
  assign cache.cache_abort  = r_abort;
  assign d_out              = r_d_out;
  assign d_out_valid        = r_d_out_valid;
  assign busy               = r_busy;
  assign rsp_err            = r_rsp_err;

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Directed bench for ifq_fetch_ctrl: issue, credits, outstanding cap, flush and reset cases.
module tb_ifq_fetch_ctrl;

  logic         clk;
  logic         rst;
  logic         fetch_en;
  logic [31:0]  pc_in;
  logic         jmp_branch_valid;
  logic         ifq_line_free;
  logic         pc_advance;
  logic [127:0] d_out;
  logic         d_out_valid;
  logic         busy;
  logic         rsp_err;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           nx;

  ifq_fetch_ctrl_if #(.DATA_WIDTH(32), .CACHE_LINE_WIDTH(128)) bus ();

  ifq_fetch_ctrl #(
    .DATA_WIDTH(32), .CACHE_LINE_WIDTH(128), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_en         (fetch_en),
    .pc_in            (pc_in),
    .jmp_branch_valid (jmp_branch_valid),
    .ifq_line_free    (ifq_line_free),
    .pc_advance       (pc_advance),
    .cache            (bus),
    .d_out            (d_out),
    .d_out_valid      (d_out_valid),
    .busy             (busy),
    .rsp_err          (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fetch_en = 1'b0; pc_in = '0; jmp_branch_valid = 1'b0; ifq_line_free = 1'b0;
    bus.cache_req_ready = 1'b0; bus.cache_rsp_valid = 1'b0; bus.cache_rsp_data = '0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  // Runs n cycles counting transfers; with imm set, answers each transfer one cycle later.
  task automatic xfer_loop(input int n, input bit imm, output int cnt);
    logic prev;
    prev = 1'b0;
    cnt  = 0;
    for (int i = 0; i < n; i++) begin
      bus.cache_rsp_valid = imm & prev;
      #1;
      prev = pc_advance;
      cnt += int'(pc_advance);
      cyc();
    end
    bus.cache_rsp_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req", bus.cache_rd_req, 0);
    chk("rst_addr", bus.cache_addr, 0);
    chk("rst_adv", pc_advance, 0);
    chk("rst_abort", bus.cache_abort, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dvalid", d_out_valid, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_err", rsp_err, 0);

    // First fetch after reset release
    fetch_en = 1'b1; pc_in = 32'h100; bus.cache_req_ready = 1'b1; rst = 1'b1;
    #1; chk("t1_idle_req", bus.cache_rd_req, 0);
    cyc();
    #1;
    chk("t1_req", bus.cache_rd_req, 1);
    chk("t1_addr", bus.cache_addr, 32'h100);
    chk("t1_adv", pc_advance, 1);
    cyc();
    bus.cache_req_ready = 1'b0; pc_in = 32'h118;
    #1;
    chk("t1_busy", busy, 1);
    chk("t1_hold_req", bus.cache_rd_req, 1);
    chk("t1_hold_adv", pc_advance, 0);
    chk("t1_hold_addr", bus.cache_addr, 32'h110);
    cyc();
    bus.cache_rsp_valid = 1'b1; bus.cache_rsp_data = {32{4'hA}};
    #1; chk("t1_dvalid_early", d_out_valid, 0);
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t1_dvalid", d_out_valid, 1);
    chk("t1_dout", d_out, {32{4'hA}});
    cyc();
    #1; chk("t1_dvalid_drop", d_out_valid, 0);

    // Credit exhaustion and single credit return
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h200; bus.cache_req_ready = 1'b1;
    xfer_loop(8, 1'b1, nx);
    chk("t2_xfers", nx, 4);
    ifq_line_free = 1'b1;
    #1; chk("t2_req_nocred", bus.cache_rd_req, 0);
    cyc();
    ifq_line_free = 1'b0;
    #1;
    chk("t2_req_free", bus.cache_rd_req, 1);
    chk("t2_adv_free", pc_advance, 1);
    cyc();
    bus.cache_rsp_valid = 1'b1;
    #1; chk("t2_req_after", bus.cache_rd_req, 0);
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1; chk("t2_err", rsp_err, 0);

    // Outstanding cap
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h300; bus.cache_req_ready = 1'b1;
    xfer_loop(6, 1'b0, nx);
    chk("t3_xfers", nx, 2);
    #1; chk("t3_req_cap", bus.cache_rd_req, 0);
    bus.cache_rsp_valid = 1'b1; bus.cache_rsp_data = {32{4'h5}};
    #1; chk("t3_req_rsp", bus.cache_rd_req, 0);
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t3_req_again", bus.cache_rd_req, 1);
    chk("t3_adv_again", pc_advance, 1);
    chk("t3_dvalid", d_out_valid, 1);
    chk("t3_dout", d_out, {32{4'h5}});
    cyc();
    #1; chk("t3_req_cap2", bus.cache_rd_req, 0);

    // Branch with two requests in flight
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h1000; bus.cache_req_ready = 1'b1;
    xfer_loop(3, 1'b0, nx);
    chk("t4_xfers", nx, 2);
    jmp_branch_valid = 1'b1; pc_in = 32'h2004;
    #1; chk("t4_req_jmp", bus.cache_rd_req, 0);
    cyc();
    jmp_branch_valid = 1'b0;
    bus.cache_rsp_valid = 1'b1; bus.cache_rsp_data = {32{4'hB}};
    #1;
    chk("t4_abort1", bus.cache_abort, 1);
    chk("t4_busy", busy, 1);
    chk("t4_req_flush", bus.cache_rd_req, 0);
    cyc();
    #1;
    chk("t4_drop1", d_out_valid, 0);
    chk("t4_abort2", bus.cache_abort, 1);
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t4_drop2", d_out_valid, 0);
    chk("t4_abort_off", bus.cache_abort, 0);
    chk("t4_req_run", bus.cache_rd_req, 1);
    chk("t4_addr", bus.cache_addr, 32'h2000);
    xfer_loop(8, 1'b1, nx);
    chk("t4_credit_reload", nx, 4);

    // Branch coinciding with a response
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h3000; bus.cache_req_ready = 1'b1;
    xfer_loop(3, 1'b0, nx);
    jmp_branch_valid = 1'b1; pc_in = 32'h4000;
    bus.cache_rsp_valid = 1'b1; bus.cache_rsp_data = {32{4'hD}};
    cyc();
    jmp_branch_valid = 1'b0; bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t5_drop_jmp", d_out_valid, 0);
    chk("t5_abort1", bus.cache_abort, 1);
    cyc();
    bus.cache_rsp_valid = 1'b1;
    #1;
    chk("t5_abort_wait", bus.cache_abort, 1);
    chk("t5_req_flush", bus.cache_rd_req, 0);
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t5_drop2", d_out_valid, 0);
    chk("t5_abort_off", bus.cache_abort, 0);
    chk("t5_req_run", bus.cache_rd_req, 1);
    chk("t5_addr", bus.cache_addr, 32'h4000);

    // Reset while a request is held
    do_reset();
    fetch_en = 1'b1; pc_in = 32'h5000; bus.cache_req_ready = 1'b1;
    xfer_loop(3, 1'b0, nx);
    bus.cache_req_ready = 1'b0;
    bus.cache_rsp_valid = 1'b1; bus.cache_rsp_data = {32{4'hC}};
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t6_req_held", bus.cache_rd_req, 1);
    chk("t6_dout", d_out, {32{4'hC}});
    rst = 1'b0;
    cyc();
    rst = 1'b1; fetch_en = 1'b0;
    #1;
    chk("t6_req", bus.cache_rd_req, 0);
    chk("t6_addr", bus.cache_addr, 0);
    chk("t6_adv", pc_advance, 0);
    chk("t6_abort", bus.cache_abort, 0);
    chk("t6_busy", busy, 0);
    chk("t6_dvalid", d_out_valid, 0);
    chk("t6_dout0", d_out, 0);
    chk("t6_err0", rsp_err, 0);
    bus.cache_rsp_valid = 1'b1;
    cyc();
    bus.cache_rsp_valid = 1'b0;
    #1;
    chk("t6_err1", rsp_err, 1);
    chk("t6_late_drop", d_out_valid, 0);
    cyc();
    #1; chk("t6_err_sticky", rsp_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifq_fetch_ctrl.md
Name: ifq_fetch_ctrl

Overview:
- Sequences I-cache line reads that fill the instruction fetch queue.
- Issues line-aligned read requests from the IFQ fetch PC and throttles them with a credit count of free FIFO lines plus a cap on outstanding requests.
- Advances the IFQ fetch PC only on an accepted request.
- On a jump/branch, flushes in-flight requests and discards their stale responses.
- Sits between the IFQ (drives pc_in, consumes d_out/d_out_valid) and the I-cache request/response port.

Parameters:
- DATA_WIDTH, 32, address/instruction width.
- CACHE_LINE_WIDTH, 128, cache line width (4 instructions).
- FIFO_DEPTH, 4, IFQ line entries = initial credit count.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered cache requests.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_en  in  1  enables fetching; 0 parks the FSM in IDLE.
- pc_in  in  DATA_WIDTH  IFQ fetch PC (branch-muxed).
- jmp_branch_valid  in  1  redirect/flush pulse.
- ifq_line_free  in  1  pulse: the IFQ retired one line (credit return).
- pc_advance  out  1  comb: advance the IFQ fetch PC (= cache_rd_req & cache_req_ready).
- cache_rd_req  out  1  comb read request.
- cache_addr  out  DATA_WIDTH  comb {pc_in[DATA_WIDTH-1:4], 4'b0}.
- cache_req_ready  in  1  cache accepts the request.
- cache_rsp_valid  in  1  response line valid.
- cache_rsp_data  in  CACHE_LINE_WIDTH  response line.
- cache_abort  out  1  registered; high throughout FLUSH.
- d_out  out  CACHE_LINE_WIDTH  registered line to the IFQ.
- d_out_valid  out  1  registered line valid to the IFQ.
- busy  out  1  registered; outstanding != 0 or state != IDLE.
- rsp_err  out  1  sticky: response received with outstanding == 0.

Behaviour:
- Reset (rst == 0 at a clock edge, including mid-operation):
  - state = IDLE, credits = FIFO_DEPTH, outstanding = 0, kill_cnt = 0.
  - d_out = 0; d_out_valid, cache_abort, busy, rsp_err = 0.
  - Comb outputs are 0 while state = IDLE.
- States:
  - IDLE -> RUN when fetch_en = 1.
  - RUN -> IDLE when fetch_en = 0 and no request is pending.
  - RUN -> FLUSH on jmp_branch_valid when (outstanding − rsp this cycle) > 0; otherwise stay in RUN.
  - FLUSH -> RUN when kill_cnt reaches 0 (next cycle).
  - jmp_branch_valid in IDLE only resets credits.
- Issue:
  - cache_rd_req = (state == RUN) & credits > 0 & outstanding < MAX_OUTSTANDING & !jmp_branch_valid.
  - Once raised, the request and address are held stable until accepted; pc_in does not move because pc_advance is low.
  - Transfer occurs on req & ready: outstanding +1, credits −1.
- Credits:
  - ifq_line_free gives +1, saturating at FIFO_DEPTH.
  - Issue and free in the same cycle give a net change of 0.
  - jmp_branch_valid reloads credits to FIFO_DEPTH; reload wins over a simultaneous free or issue.
- Response:
  - Every cache_rsp_valid decrements outstanding.
  - If kill_cnt == 0 and no flush is in progress this cycle: d_out <= cache_rsp_data and d_out_valid <= 1 on the next cycle (1-cycle latency). Otherwise the response is dropped and kill_cnt −1.
  - Issue and response in the same cycle give a net outstanding change of 0.
- Flush:
  - Cycle N with jmp_branch_valid: no issue; a response arriving in cycle N is dropped.
  - kill_cnt <= outstanding − (cache_rsp_valid ? 1 : 0).
  - cache_abort is high from N+1 through the last FLUSH cycle.
  - The first new request is issued in the cycle after FLUSH exits, with addr = aligned branch pc_in.
  - A further jmp_branch_valid during FLUSH reloads credits; kill_cnt is unchanged.
- Width and error rules:
  - outstanding and kill_cnt are $clog2(MAX_OUTSTANDING+1) bits wide; credits are $clog2(FIFO_DEPTH+1) bits wide.
  - A response with outstanding == 0 is ignored and sets rsp_err; no underflow occurs.

Decomposition:
- Package ifq_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t.
  - Line-offset constant LINE_OFFSET_BITS = 4.
- One sub-module: up_down_sat_counter (inc, dec, load, load_val, saturation max). Instantiate it for credits and outstanding.

Test Plan:
- Reset release, fetch_en = 1, pc_in = 0x100, ready = 1: cache_rd_req with addr 0x100 and pc_advance in the 2nd cycle. rsp_valid with data 0xA..A two cycles later gives d_out_valid = 1 and d_out = 0xA..A one cycle after the response.
- Credits: ready = 1, immediate responses, no ifq_line_free: exactly 4 transfers, then cache_rd_req = 0. One ifq_line_free pulse gives exactly one further transfer on the next cycle.
- Outstanding cap: ready = 1, no responses: 2 transfers, then req = 0 with credits = 2. One response re-enables a single issue.
- Branch with 2 outstanding: jmp_branch_valid with pc_in = 0x2000 gives FLUSH and cache_abort = 1. Two responses are dropped (d_out_valid stays 0), then RUN, and the next request has addr 0x2000 with credits = 4.
- Branch in the same cycle as a response with outstanding = 2: that response is dropped, kill_cnt = 1, one more dropped response, then RUN.
- Reset mid-operation with req held (ready = 0, outstanding = 1): the cycle after rst = 0, all outputs are 0, state = IDLE, and rsp_err = 0. A late response after reset sets rsp_err = 1.
